// File: rtl/mp_add_sched.sv
// Shares one mp_adder among NREQ requesters. Grants round-robin within the current data type
// and drains the adder pipeline before switching between integer and FP16 mode.
module mp_add_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MAX_RUN = 8,
  localparam int unsigned IdW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned RunW   = $clog2(MAX_RUN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_dtype_i,
  input  logic [36*NREQ-1:0]   req_opa_i,
  input  logic [32*NREQ-1:0]   req_opb_i,
  output logic                 add_en_o,
  output logic                 add_dtype_o,
  output logic [35:0]          add_opa_o,
  output logic [31:0]          add_opb_o,
  input  logic [35:0]          add_sum_i,
  output logic                 rsp_valid_o,
  output logic [IdW-1:0]       rsp_id_o,
  output logic [35:0]          rsp_sum_o
);

  typedef enum logic {StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic              md_q, md_d;
  logic [RunW-1:0]   run_q, run_d;
  logic [IdW-1:0]    ptr_q, ptr_d;

  logic              iss_vld_q;
  logic [IdW-1:0]    iss_id_q;
  logic [35:0]       opa_q;
  logic [31:0]       opb_q;
  logic [ADD_LAT-1:0] tag_vld_q;
  logic [IdW-1:0]    tag_id_q [ADD_LAT];

  logic [NREQ-1:0]   match, other;
  logic              any_match, any_other, run_sat, pipe_empty;
  logic              gnt_found, fire, drain_done;
  logic [IdW-1:0]    gnt_id;
  logic [IdW:0]      rr_idx;
  logic [35:0]       sel_opa;
  logic [31:0]       sel_opb;

  assign match      = req_valid_i & (md_q ? req_dtype_i : ~req_dtype_i);
  assign other      = req_valid_i & (md_q ? ~req_dtype_i : req_dtype_i);
  assign any_match  = |match;
  assign any_other  = |other;
  assign run_sat    = (run_q == RunW'(MAX_RUN));
  assign pipe_empty = !iss_vld_q && !(|tag_vld_q);

  // Round-robin search starting one past the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = {1'b0, ptr_q} + (IdW+1)'(k);
      if (rr_idx >= (IdW+1)'(NREQ)) rr_idx = rr_idx - (IdW+1)'(NREQ);
      if (!gnt_found && match[rr_idx[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    sel_opa = '0;
    sel_opb = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id == IdW'(i)) begin
        sel_opa = req_opa_i[36*i +: 36];
        sel_opb = req_opb_i[32*i +: 32];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIssue;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIssue: if (any_other && (!any_match || run_sat)) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StIssue;
      default: state_d = StIssue;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fire       = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      StIssue: fire = gnt_found && !(any_other && run_sat);
      StDrain: drain_done = pipe_empty;
      default: ;
    endcase
  end

  always_comb begin
    md_d  = md_q;
    run_d = run_q;
    ptr_d = fire ? gnt_id : ptr_q;
    if (drain_done) begin
      md_d  = ~md_q;
      run_d = '0;
    end else if (fire && !run_sat) begin
      run_d = run_q + RunW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      md_q      <= 1'b0;
      run_q     <= '0;
      ptr_q     <= IdW'(NREQ - 1);
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      md_q        <= md_d;
      run_q       <= run_d;
      ptr_q       <= ptr_d;
      iss_vld_q   <= fire;
      iss_id_q    <= gnt_id;
      opa_q       <= fire ? sel_opa : '0;
      opb_q       <= fire ? sel_opb : '0;
      // Tag stages track the op through the adder, starting from the issue slot.
      tag_vld_q[0] <= iss_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (fire && !rst_i) req_ready_o[gnt_id] = 1'b1;
  end

  // Outputs are forced quiet combinationally while reset is held.
  assign add_en_o    = !rst_i;
  assign add_dtype_o = md_q & !rst_i;
  assign add_opa_o   = rst_i ? '0 : opa_q;
  assign add_opb_o   = rst_i ? '0 : opb_q;
  assign rsp_valid_o = tag_vld_q[ADD_LAT-1] & !rst_i;
  assign rsp_id_o    = rst_i ? '0 : tag_id_q[ADD_LAT-1];
  assign rsp_sum_o   = add_sum_i;

endmodule

// File: tb/tb_mp_add_sched.sv
// Directed bench for mp_add_sched with a small pipelined mp_adder stand-in.
module tb_mp_add_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned MAX_RUN = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i, req_ready_o, req_dtype_i;
  logic [36*NREQ-1:0] req_opa_i;
  logic [32*NREQ-1:0] req_opb_i;
  logic              add_en_o, add_dtype_o;
  logic [35:0]       add_opa_o;
  logic [31:0]       add_opb_o;
  logic [35:0]       add_sum_i;
  logic              rsp_valid_o;
  logic [1:0]        rsp_id_o;
  logic [35:0]       rsp_sum_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mp_add_sched #(
    .NREQ    (NREQ),
    .ADD_LAT (ADD_LAT),
    .MAX_RUN (MAX_RUN)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_dtype_i (req_dtype_i),
    .req_opa_i   (req_opa_i),
    .req_opb_i   (req_opb_i),
    .add_en_o    (add_en_o),
    .add_dtype_o (add_dtype_o),
    .add_opa_o   (add_opa_o),
    .add_opb_o   (add_opb_o),
    .add_sum_i   (add_sum_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_sum_o   (rsp_sum_o)
  );

  // Adder stand-in: FP16 path handles positive normal operands only.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  e;
    logic [11:0] m;
    x = (a[14:10] >= b[14:10]) ? a : b;
    y = (a[14:10] >= b[14:10]) ? b : a;
    e = x[14:10];
    m = {1'b0, 1'b1, x[9:0]} + ({1'b0, 1'b1, y[9:0]} >> (x[14:10] - y[14:10]));
    if (m[11]) begin
      m = m >> 1;
      e = e + 5'd1;
    end
    return {1'b0, e, m[9:0]};
  endfunction

  function automatic logic [35:0] add_model(input logic dt, input logic [35:0] a,
                                            input logic [31:0] b);
    if (dt) return {20'h0, fp16_add(a[15:0], b[15:0])};
    return a + {{4{b[31]}}, b};
  endfunction

  logic [35:0] add_pipe_q [ADD_LAT];
  always_ff @(posedge clk_i) begin
    if (add_en_o) begin
      add_pipe_q[0] <= add_model(add_dtype_o, add_opa_o, add_opb_o);
      for (int i = 1; i < ADD_LAT; i++) add_pipe_q[i] <= add_pipe_q[i-1];
    end
  end
  assign add_sum_i = add_pipe_q[ADD_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  initial begin
    int n0, gcyc, pulses;
    logic dt;
    rst_i       = 1'b1;
    req_valid_i = '1;
    req_dtype_i = '0;
    req_opa_i   = '0;
    req_opb_i   = '0;

    // Outputs held quiet during reset even with requests pending.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ready", 64'(req_ready_o), 64'(0));
    check_eq("rst_en", 64'(add_en_o), 64'(0));
    check_eq("rst_dtype", 64'(add_dtype_o), 64'(0));
    check_eq("rst_opa", 64'(add_opa_o), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check_eq("rst_rsp_id", 64'(rsp_id_o), 64'(0));

    // Single integer op: 5 + (-3) = 2, response three cycles after accept.
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_valid_i = 4'b0001;
    req_opa_i[35:0] = 36'd5;
    req_opb_i[31:0] = 32'hFFFF_FFFD;
    @(negedge clk_i);
    check_eq("int_ready", 64'(req_ready_o), 64'(4'b0001));
    @(posedge clk_i); #1 req_valid_i = '0;
    @(negedge clk_i);
    check_eq("int_en", 64'(add_en_o), 64'(1));
    check_eq("int_opa", 64'(add_opa_o), 64'(5));
    check_eq("int_opb", 64'(add_opb_o), 64'(32'hFFFF_FFFD));
    check_eq("int_rsp_early1", 64'(rsp_valid_o), 64'(0));
    @(negedge clk_i);
    check_eq("int_rsp_early2", 64'(rsp_valid_o), 64'(0));
    @(negedge clk_i);
    check_eq("int_rsp_valid", 64'(rsp_valid_o), 64'(1));
    check_eq("int_rsp_id", 64'(rsp_id_o), 64'(0));
    check_eq("int_rsp_sum", 64'(rsp_sum_o), 64'(2));
    @(negedge clk_i);
    check_eq("int_rsp_after", 64'(rsp_valid_o), 64'(0));

    // Round-robin from reset: grants 0,1,2,3,0; lane i computes (100+i)+i.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_opa_i[36*i +: 36] = 36'(100 + i);
      req_opb_i[32*i +: 32] = 32'(i);
    end
    req_dtype_i = '0;
    req_valid_i = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (k < 5) check_eq("rr_grant", 64'(req_ready_o), 64'(1 << (k % 4)));
      if (k >= 3) begin
        check_eq("rr_rsp_valid", 64'(rsp_valid_o), 64'(1));
        check_eq("rr_rsp_id", 64'(rsp_id_o), 64'((k - 3) % 4));
        check_eq("rr_rsp_sum", 64'(rsp_sum_o), 64'(100 + 2 * ((k - 3) % 4)));
      end
      @(posedge clk_i); #1;
      if (k == 4) req_valid_i = '0;
    end

    // Mode switch: lone FP16 request while in integer mode.
    repeat (2) begin @(posedge clk_i); #1; end
    req_dtype_i = 4'b0010;
    req_opa_i[71:36] = 36'h3C00;
    req_opb_i[63:32] = 32'h3C00;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    check_eq("ms_ready_c0", 64'(req_ready_o), 64'(0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("ms_ready_c1", 64'(req_ready_o), 64'(0));
    check_eq("ms_dtype_c1", 64'(add_dtype_o), 64'(0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("ms_ready_c2", 64'(req_ready_o), 64'(4'b0010));
    check_eq("ms_dtype_c2", 64'(add_dtype_o), 64'(1));
    @(posedge clk_i); #1 req_valid_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("ms_rsp_valid", 64'(rsp_valid_o), 64'(1));
    check_eq("ms_rsp_id", 64'(rsp_id_o), 64'(1));
    check_eq("ms_rsp_sum", 64'(rsp_sum_o), 64'(36'h4000));

    // Starvation: req0 integer vs req2 FP16; 8 integer grants, 4-cycle gap, then req2.
    do_reset();
    req_dtype_i = 4'b0100;
    req_valid_i = 4'b0101;
    n0   = 0;
    gcyc = -1;
    dt   = 1'b0;
    for (int k = 0; k < 40 && gcyc < 0; k++) begin
      @(negedge clk_i);
      if (req_ready_o == 4'b0001) n0++;
      else if (req_ready_o == 4'b0100) begin
        gcyc = k;
        dt   = add_dtype_o;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    check_eq("starve_req0_grants", 64'(n0), 64'(MAX_RUN));
    check_eq("starve_req2_cycle", 64'(gcyc), 64'(12));
    check_eq("starve_req2_dtype", 64'(dt), 64'(1));

    // Reset one cycle after two accepts: in-flight results vanish, pointer restarts at 0.
    do_reset();
    req_dtype_i = '0;
    req_valid_i = '1;
    @(negedge clk_i);
    check_eq("rmf_grant0", 64'(req_ready_o), 64'(4'b0001));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("rmf_grant1", 64'(req_ready_o), 64'(4'b0010));
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rmf_rst_ready", 64'(req_ready_o), 64'(0));
    check_eq("rmf_rst_en", 64'(add_en_o), 64'(0));
    check_eq("rmf_rst_opa", 64'(add_opa_o), 64'(0));
    check_eq("rmf_rst_rsp", 64'(rsp_valid_o), 64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_valid_i = '0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (rsp_valid_o) pulses++;
    end
    check_eq("rmf_no_rsp", 64'(pulses), 64'(0));
    @(posedge clk_i); #1 req_valid_i = '1;
    @(negedge clk_i);
    check_eq("rmf_first_grant", 64'(req_ready_o), 64'(4'b0001));
    @(posedge clk_i); #1 req_valid_i = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mp_add_sched.md
MP_ADD_SCHED -- requirements
Module: mp_add_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one mp_adder.
REQ-002 SHALL have parameter ADD_LAT, default 2: mp_adder latency in cycles from operand/enable presentation to sum_o.
REQ-003 SHALL have parameter MAX_RUN, default 8: maximum consecutive same-type issues while an other-type request waits.
REQ-004 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i  in  NREQ  per-requester operation valid.
REQ-007 SHALL have port req_ready_o  out  NREQ  per-requester accept (one-hot or zero).
REQ-008 SHALL have port req_dtype_i  in  NREQ  per-requester data type: 0 integer, 1 FP16.
REQ-009 SHALL have port req_opa_i  in  36*NREQ  flattened operand A; requester i occupies bits [36i+35:36i].
REQ-010 SHALL have port req_opb_i  in  32*NREQ  flattened operand B; requester i occupies bits [32i+31:32i].
REQ-011 SHALL have port add_en_o  out  1  mp_adder en_i.
REQ-012 SHALL have port add_dtype_o  out  1  mp_adder data_type_i.
REQ-013 SHALL have port add_opa_o  out  36  mp_adder opa_i.
REQ-014 SHALL have port add_opb_o  out  32  mp_adder opb_i.
REQ-015 SHALL have port add_sum_i  in  36  mp_adder sum_o.
REQ-016 SHALL have port rsp_valid_o  out  1  result valid for one cycle; no backpressure.
REQ-017 SHALL have port rsp_id_o  out  clog2(NREQ)  index of the requester that owns the result.
REQ-018 SHALL have port rsp_sum_o  out  36  result, equal to add_sum_i.

Function
REQ-019 SHALL implement FSM states ISSUE and DRAIN; current mode register md holds the active data type.
REQ-020 In ISSUE, SHALL grant at most one requester per cycle with valid=1 and dtype==md, round-robin, starting the search at the index after the last grant.
REQ-021 SHALL drive req_ready_o combinationally equal to the grant; a transfer is valid&ready in the same cycle.
REQ-022 SHALL register the granted opa/opb onto add_opa_o/add_opb_o in the next cycle (issue slot); non-issue slots drive both to 0.
REQ-023 SHALL hold add_en_o=1 in every cycle after reset release, so the mp_adder pipeline never freezes.
REQ-024 SHALL drive add_dtype_o = md and change md only in DRAIN once the pipeline is empty; md is never changed while any op is in flight.
REQ-025 SHALL carry a tag {valid, id} through a shift register of ADD_LAT stages aligned with the issue slot, so rsp_valid_o/rsp_id_o coincide with the matching add_sum_i.
REQ-026 Accept-to-response latency SHALL be exactly ADD_LAT+1 cycles (3 with the default); throughput 1 op/cycle within one mode.
REQ-027 ISSUE->DRAIN SHALL occur when no valid request matches md but one of the other type is pending, or when run count reaches MAX_RUN with an other-type request pending; no grant in the transition cycle.
REQ-028 Run count SHALL increment per issue, clear on mode switch, and saturate at MAX_RUN.
REQ-029 DRAIN SHALL issue nothing, wait until the issue slot and all tag stages are invalid, then toggle md, clear run count, and return to ISSUE.
REQ-030 With no valid requests, the FSM SHALL stay in ISSUE with md unchanged, and rsp_valid_o SHALL go low after in-flight results drain.
REQ-031 A requester deasserting valid without a handshake SHALL have no effect; operands are sampled only in the handshake cycle.

Reset
REQ-032 On rst_i=1 at a clock edge SHALL set FSM=ISSUE, md=0, run count=0, round-robin pointer=NREQ-1 (requester 0 highest priority first), and clear all tags.
REQ-033 During reset SHALL hold req_ready_o=0, add_en_o=0, add_dtype_o=0, add_opa_o=0, add_opb_o=0, rsp_valid_o=0, rsp_id_o=0.
REQ-034 Reset mid-operation SHALL discard in-flight tags; no rsp_valid_o pulse for ops accepted before reset.

Verification
REQ-035 Integer single op: req0 opa=5, opb=-3 (0xFFFFFFFD), dtype 0 at cycle t -> ready0=1 at t; rsp_valid=1, id=0, sum=2 at t+3.
REQ-036 Round-robin: all four requesters hold valid with dtype 0 -> grants 0,1,2,3,0 on consecutive cycles; responses return in the same order.
REQ-037 Mode switch: req1 FP16 0x3C00+0x3C00 pending while md=0 and idle -> DRAIN waits for empty pipeline, md=1, then grant; response sum=0x4000.
REQ-038 Starvation: req0 continuously valid with dtype 0 and req2 valid with dtype 1 -> exactly MAX_RUN=8 grants to req0, then drain, then req2 granted.
REQ-039 Reset mid-flight: assert rst_i one cycle after two accepts -> no rsp_valid_o afterwards; first post-reset grant goes to requester 0.
